// File: rtl/fptd_branch_metric.sv
// Branch-metric stage for one trellis stage of the fully parallel turbo decoder.
// Latches channel LLRs per codeword and registers a priori-combined sums once per iteration.
module fptd_branch_metric #(
    parameter int N       = 5,
    parameter int M       = 6,
    parameter int MaxIter = 8
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                Start,
    input  logic signed [N-1:0] llr_sys,
    input  logic signed [N-1:0] llr_par,
    input  logic signed [M-1:0] apriori,
    input  logic                Stall,
    output logic signed [N-1:0] ba2,
    output logic signed [M:0]   ba1ba3,
    output logic signed [M:0]   ba1ba2ba3,
    output logic [7:0]          iter_cnt,
    output logic                Busy,
    output logic                Done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic signed [N-1:0] sys_q;
    logic signed [N-1:0] par_q;
    logic signed [M-1:0] a1;
    logic signed [M:0]   sys_ext;
    logic signed [M:0]   par_ext;
    logic signed [M:0]   a1_ext;
    logic                last_iter;

    // With N <= M-1 the three-operand sum always fits in M+1 bits, so no saturation is needed.
    if (N > M - 1) begin : g_width_check
        $error("fptd_branch_metric: N must be <= M-1");
    end

    assign a1        = (iter_cnt == 8'd0) ? '0 : apriori;
    assign sys_ext   = {{(M + 1 - N){sys_q[N-1]}}, sys_q};
    assign par_ext   = {{(M + 1 - N){par_q[N-1]}}, par_q};
    assign a1_ext    = {a1[M-1], a1};
    assign last_iter = (iter_cnt == 8'(MaxIter - 1));

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state     <= IDLE;
            sys_q     <= '0;
            par_q     <= '0;
            ba2       <= '0;
            ba1ba3    <= '0;
            ba1ba2ba3 <= '0;
            iter_cnt  <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        sys_q    <= llr_sys;
                        par_q    <= llr_par;
                        iter_cnt <= '0;
                        Busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    // A stalled cycle holds everything so razor-corrected metrics see the same inputs.
                    if (!Stall) begin
                        ba2       <= par_q;
                        ba1ba3    <= a1_ext + sys_ext;
                        ba1ba2ba3 <= a1_ext + sys_ext + par_ext;
                        if (last_iter) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            iter_cnt <= iter_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
